// File: rtl/regfile_result_checker_pkg.sv
// Shared types and constants for the register-file result checker.
//   state_e    : checker FSM state encoding (2 bits)
//   FAIL_NONE  : fail_index value meaning "no mismatch recorded"
//   ERR_MAX    : saturation value of the error counter
//   EXP_*      : expected register contents, one per checked index
package regfile_result_checker_pkg;

  localparam int unsigned IDX_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ERR_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [IDX_W-1:0] FAIL_NONE = 5'h1F;
  localparam logic [ERR_W-1:0] ERR_MAX   = 8'hFF;

  localparam logic [DATA_W-1:0] EXP_00 = 32'd65535;
  localparam logic [DATA_W-1:0] EXP_01 = 32'd2147450880;
  localparam logic [DATA_W-1:0] EXP_02 = 32'd2147483647;
  localparam logic [DATA_W-1:0] EXP_03 = 32'd0;
  localparam logic [DATA_W-1:0] EXP_04 = 32'd0;
  localparam logic [DATA_W-1:0] EXP_05 = 32'd0;
  localparam logic [DATA_W-1:0] EXP_06 = 32'd1;
  localparam logic [DATA_W-1:0] EXP_07 = 32'd2;
  localparam logic [DATA_W-1:0] EXP_08 = 32'd3;
  localparam logic [DATA_W-1:0] EXP_09 = 32'd0;
  localparam logic [DATA_W-1:0] EXP_10 = 32'd0;
  localparam logic [DATA_W-1:0] EXP_11 = 32'd0;
  localparam logic [DATA_W-1:0] EXP_12 = 32'h8000_0000;
  localparam logic [DATA_W-1:0] EXP_13 = 32'hFFFF_FFFF;
  localparam logic [DATA_W-1:0] EXP_14 = 32'd0;

endpackage

// File: rtl/regfile_expected_rom.sv
// Expected-value table for the checked registers. Swap this file when the
// test program changes.
//   index_i    : checked-entry index (0..31)
//   expected_o : expected 32-bit register contents (0 beyond the table)
module regfile_expected_rom
  import regfile_result_checker_pkg::*;
(
  input  logic [IDX_W-1:0]  index_i,
  output logic [DATA_W-1:0] expected_o
);

  always_comb begin
    expected_o = '0;
    unique case (index_i)
      5'd0:    expected_o = EXP_00;
      5'd1:    expected_o = EXP_01;
      5'd2:    expected_o = EXP_02;
      5'd3:    expected_o = EXP_03;
      5'd4:    expected_o = EXP_04;
      5'd5:    expected_o = EXP_05;
      5'd6:    expected_o = EXP_06;
      5'd7:    expected_o = EXP_07;
      5'd8:    expected_o = EXP_08;
      5'd9:    expected_o = EXP_09;
      5'd10:   expected_o = EXP_10;
      5'd11:   expected_o = EXP_11;
      5'd12:   expected_o = EXP_12;
      5'd13:   expected_o = EXP_13;
      5'd14:   expected_o = EXP_14;
      default: expected_o = '0;
    endcase
  end

endmodule

// File: rtl/regfile_result_checker.sv
// Post-run register-file self check: sweeps read port B over the checked
// registers, holds each address for a settle window, compares against the
// expected table and reports pass/fail, error count and first failure.
//   clock, ctrl_reset      : clock and synchronous active-high reset
//   start                  : begin a sweep (ignored while busy)
//   ctrl_readRegA/B        : regfile read addresses (A is always r0)
//   data_readRegA/B        : regfile read data
//   busy, done, pass       : sweep status
//   error_count            : saturating mismatch count
//   fail_index, fail_data  : first mismatch index and captured B data
module regfile_result_checker
  import regfile_result_checker_pkg::*;
#(
  parameter int unsigned NUM_CHECKS    = 15,
  parameter int unsigned FIRST_REG     = 1,
  parameter int unsigned START_DELAY   = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              start,
  output logic [IDX_W-1:0]  ctrl_readRegA,
  output logic [IDX_W-1:0]  ctrl_readRegB,
  input  logic [DATA_W-1:0] data_readRegA,
  input  logic [DATA_W-1:0] data_readRegB,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  error_count,
  output logic [IDX_W-1:0]  fail_index,
  output logic [DATA_W-1:0] fail_data
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(START_DELAY - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] INDEX_LAST  = IDX_W'(NUM_CHECKS - 1);
  localparam logic [IDX_W-1:0] FIRST_ADDR  = IDX_W'(FIRST_REG);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [IDX_W-1:0]  addr_b_q, addr_b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [IDX_W-1:0]  fidx_q, fidx_d;
  logic [DATA_W-1:0] fdata_q, fdata_d;
  logic [IDX_W-1:0]  addr_a_q;

  logic [DATA_W-1:0] expected_c;
  logic              mismatch_c;

  regfile_expected_rom u_rom (
    .index_i    (index_q),
    .expected_o (expected_c)
  );

  // Port A must read r0 as zero; port B must match the table entry.
  assign mismatch_c = (data_readRegA != '0) || (data_readRegB != expected_c);

  // Next-state and result update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    index_d  = index_q;
    addr_b_d = addr_b_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fidx_d   = fidx_q;
    fdata_d  = fdata_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_DELAY;
          cnt_d   = '0;
          index_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          fidx_d  = FAIL_NONE;
          fdata_d = '0;
        end
      end
      ST_DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          state_d  = ST_SETTLE;
          cnt_d    = '0;
          addr_b_d = FIRST_ADDR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (mismatch_c) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_W'(1);
            end
            // Index never reaches 31, so FAIL_NONE doubles as "none yet".
            if (fidx_q == FAIL_NONE) begin
              fidx_d  = index_q;
              fdata_d = data_readRegB;
            end
          end
          if (index_q == INDEX_LAST) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            index_d  = index_q + IDX_W'(1);
            addr_b_d = FIRST_ADDR + index_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      index_q  <= '0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fidx_q   <= FAIL_NONE;
      fdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      index_q  <= index_d;
      addr_a_q <= '0;
      addr_b_q <= addr_b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fidx_q   <= fidx_d;
      fdata_q  <= fdata_d;
    end
  end

  assign ctrl_readRegA = addr_a_q;
  assign ctrl_readRegB = addr_b_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign error_count   = err_q;
  assign fail_index    = fidx_q;
  assign fail_data     = fdata_q;

endmodule

// File: tb/tb_regfile_result_checker.sv
// Self-checking bench for regfile_result_checker: a time-based sweep model
// predicts every output each cycle; directed scenarios pin key results.
module tb_regfile_result_checker;

  localparam int NUM_CHECKS = 15;
  localparam int FIRST_REG  = 1;
  localparam int START_DLY  = 4;
  localparam int SETTLE     = 8;
  localparam int LATENCY    = START_DLY + NUM_CHECKS * SETTLE;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_readRegA, data_readRegB;
  logic        busy, done, pass;
  logic [7:0]  error_count;
  logic [4:0]  fail_index;
  logic [31:0] fail_data;

  logic [31:0] regs [32];
  logic [31:0] exp_tab [32];
  logic        force_a = 1'b0;
  logic [31:0] a_val = 32'd0;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  regfile_result_checker dut (
    .clock         (clock),
    .ctrl_reset    (ctrl_reset),
    .start         (start),
    .ctrl_readRegA (ctrl_readRegA),
    .ctrl_readRegB (ctrl_readRegB),
    .data_readRegA (data_readRegA),
    .data_readRegB (data_readRegB),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .error_count   (error_count),
    .fail_index    (fail_index),
    .fail_data     (fail_data)
  );

  always #5 clock = ~clock;

  assign data_readRegA = force_a ? a_val : regs[ctrl_readRegA];
  assign data_readRegB = regs[ctrl_readRegB];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Behavioural model: position in the sweep is derived from elapsed cycles.
  bit          m_active;
  int          m_t;
  logic        m_busy, m_done, m_pass;
  logic [7:0]  m_err;
  logic [4:0]  m_fidx, m_addr;
  logic [31:0] m_fdata;

  always @(posedge clock) begin
    int i;
    logic [31:0] a, b;
    if (ctrl_reset) begin
      m_active = 0; m_t = 0; m_done = 0; m_pass = 0; m_err = 0;
      m_fidx = 5'h1F; m_fdata = 0; m_addr = 0;
    end else if (m_active) begin
      m_t++;
      if (m_t == START_DLY) begin
        m_addr = 5'(FIRST_REG);
      end else if (m_t > START_DLY && (m_t - START_DLY) % SETTLE == 0) begin
        i = (m_t - START_DLY) / SETTLE - 1;
        a = force_a ? a_val : 32'd0;
        b = regs[m_addr];
        if (a != 0 || b != exp_tab[i]) begin
          if (m_err != 8'hFF) m_err++;
          if (m_fidx == 5'h1F) begin
            m_fidx  = 5'(i);
            m_fdata = b;
          end
        end
        if (i == NUM_CHECKS - 1) begin
          m_active = 0; m_done = 1; m_pass = (m_err == 0);
        end else begin
          m_addr = 5'(FIRST_REG + i + 1);
        end
      end
    end else if (start) begin
      m_active = 1; m_t = 0; m_done = 0; m_pass = 0; m_err = 0;
      m_fidx = 5'h1F; m_fdata = 0;
    end
    m_busy = m_active;
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("pass", 32'(pass), 32'(m_pass));
      chk("error_count", 32'(error_count), 32'(m_err));
      chk("fail_index", 32'(fail_index), 32'(m_fidx));
      chk("fail_data", fail_data, m_fdata);
      chk("readRegA", 32'(ctrl_readRegA), 32'd0);
      if (m_active && m_t >= START_DLY)
        chk("readRegB", 32'(ctrl_readRegB), 32'(m_addr));
    end
  end

  task automatic load_table();
    for (int r = 0; r < 32; r++) regs[r] = 32'd0;
    for (int k = 0; k < NUM_CHECKS; k++) regs[5'(FIRST_REG + k)] = exp_tab[k];
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Counts cycles from the start edge to done; optional stray start pulses.
  task automatic wait_done(input int x1, input int x2, output int lat);
    int n = 0;
    while (!done && n < 400) begin
      start = (n == x1 || n == x2);
      @(negedge clock);
      n++;
    end
    start = 1'b0;
    lat = n;
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL timeout: done not seen within %0d cycles", n);
    end
  endtask

  initial begin
    int lat;
    exp_tab = '{default: 32'd0};
    exp_tab[0]  = 32'd65535;       exp_tab[1]  = 32'd2147450880;
    exp_tab[2]  = 32'd2147483647;  exp_tab[6]  = 32'd1;
    exp_tab[7]  = 32'd2;           exp_tab[8]  = 32'd3;
    exp_tab[12] = 32'h8000_0000;   exp_tab[13] = 32'hFFFF_FFFF;
    load_table();
    repeat (2) @(negedge clock);
    chk_en = 1'b1;
    repeat (2) @(negedge clock);
    ctrl_reset = 1'b0;
    chk("rst fail_index", 32'(fail_index), 32'h1F);
    chk("rst busy", 32'(busy), 32'd0);
    @(negedge clock);

    // 1: clean sweep
    pulse_start();
    chk("t1 busy", 32'(busy), 32'd1);
    wait_done(-1, -1, lat);
    chk("t1 latency", 32'(lat), 32'(LATENCY));
    chk("t1 pass", 32'(pass), 32'd1);
    chk("t1 err", 32'(error_count), 32'd0);
    chk("t1 fidx", 32'(fail_index), 32'h1F);

    // 2: r6 corrupted
    regs[6] = 32'd7;
    pulse_start();
    wait_done(-1, -1, lat);
    chk("t2 pass", 32'(pass), 32'd0);
    chk("t2 err", 32'(error_count), 32'd1);
    chk("t2 fidx", 32'(fail_index), 32'd5);
    chk("t2 fdata", fail_data, 32'd7);

    // 6: from DONE with a failure, fix and re-run
    regs[6] = 32'd0;
    pulse_start();
    chk("t6 done drop", 32'(done), 32'd0);
    chk("t6 pass drop", 32'(pass), 32'd0);
    wait_done(-1, -1, lat);
    chk("t6 latency", 32'(lat), 32'(LATENCY));
    chk("t6 pass", 32'(pass), 32'd1);
    chk("t6 fidx", 32'(fail_index), 32'h1F);

    // 3: port A forced non-zero
    force_a = 1'b1; a_val = 32'd1;
    pulse_start();
    wait_done(-1, -1, lat);
    chk("t3 err", 32'(error_count), 32'd15);
    chk("t3 fidx", 32'(fail_index), 32'd0);
    chk("t3 fdata", fail_data, 32'd65535);
    chk("t3 pass", 32'(pass), 32'd0);
    force_a = 1'b0;

    // 4: reset mid-sweep at cycle 40
    pulse_start();
    repeat (39) @(negedge clock);
    ctrl_reset = 1'b1;
    @(negedge clock);
    ctrl_reset = 1'b0;
    chk("t4 busy", 32'(busy), 32'd0);
    chk("t4 done", 32'(done), 32'd0);
    chk("t4 err", 32'(error_count), 32'd0);
    chk("t4 fidx", 32'(fail_index), 32'h1F);
    chk("t4 readB", 32'(ctrl_readRegB), 32'd0);
    @(negedge clock);
    pulse_start();
    wait_done(-1, -1, lat);
    chk("t4 latency", 32'(lat), 32'(LATENCY));
    chk("t4 pass", 32'(pass), 32'd1);

    // 5: stray start pulses mid-sweep
    regs[6] = 32'd7;
    pulse_start();
    wait_done(2, 60, lat);
    chk("t5 latency", 32'(lat), 32'(LATENCY));
    chk("t5 err", 32'(error_count), 32'd1);
    chk("t5 fidx", 32'(fail_index), 32'd5);

    // Randomized sweeps against the model
    for (int r = 0; r < 10; r++) begin
      load_table();
      for (int k = 0; k < int'($urandom_range(0, 4)); k++)
        regs[5'($urandom_range(1, 31))] = $urandom();
      force_a = ($urandom_range(0, 3) == 0);
      a_val = force_a ? ($urandom() | 32'd1) : 32'd0;
      repeat ($urandom_range(0, 3)) @(negedge clock);
      pulse_start();
      wait_done(int'($urandom_range(1, 120)), int'($urandom_range(1, 120)), lat);
      chk("rnd latency", 32'(lat), 32'(LATENCY));
    end
    force_a = 1'b0;
    repeat (3) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
